vbm_sched: RTL and testbench

- Scheduler that shares one variable bit-width multiplier (16x16, or two parallel 8x8 lanes) between two requesters.
- Each requester issues either 16-bit or 8-bit multiply requests.
- Pairs coincident 8-bit requests into a single parallel-mode operation; otherwise grants round-robin.
- Pipelines the multiplier result and steers each product back to its owner.

---
 rtl/vbm_sched.sv | 248 ++++++++++++++++++++++++
 tb/tb_vbm_sched.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/vbm_sched.sv
// vbm_sched: shares one variable bit-width multiplier (one 16x16 product, or
// two parallel 8x8 lanes) between two requesters.
//
// Issue policy:
//   - Coincident 8-bit requests are paired into one parallel-mode issue.
//   - Other contention is granted round-robin.
//   - A lone 8-bit request waits up to PAIR_WAIT cycles for a partner.
// The product travels down a LAT-deep pipeline, tagged with its owner(s)
// and the mode, and is steered back to the owning requester(s).
//
// Optional feature: define VBM_SCHED_STATS_EN to enable the three wrapping
// issue counters. Without it, the stat outputs are tied to 0.
//
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   req_valid/ready/mode[1:0] per-requester handshake; mode 1 = 8-bit op
//   req_a0/b0, req_a1/b1      16-bit operands (8-bit ops use [7:0])
//   rsp_valid[1:0]            one-cycle response pulse per requester
//   rsp_p0, rsp_p1            products; they hold between pulses
//   stat_n16/npair/nsgl8      issue counters
module vbm_sched #(
    parameter int LAT       = 2,
    parameter int PAIR_WAIT = 3,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [1:0]       req_valid,
    output logic [1:0]       req_ready,
    input  logic [1:0]       req_mode,
    input  logic [15:0]      req_a0,
    input  logic [15:0]      req_b0,
    input  logic [15:0]      req_a1,
    input  logic [15:0]      req_b1,
    output logic [1:0]       rsp_valid,
    output logic [31:0]      rsp_p0,
    output logic [31:0]      rsp_p1,
    output logic [CNT_W-1:0] stat_n16,
    output logic [CNT_W-1:0] stat_npair,
    output logic [CNT_W-1:0] stat_nsgl8
);

    typedef enum logic [0:0] {IDLE = 1'b0, WAIT_PAIR = 1'b1} state_e;

    localparam int CW = (PAIR_WAIT > 1) ? $clog2(PAIR_WAIT) : 1;
    // Register stages in front of the output registers.
    localparam int SD = (LAT > 1) ? LAT - 1 : 1;

    state_e        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          rr_q, rr_d;

    logic          issue_s;
    logic          para_s;
    logic [1:0]    own_s;
    logic [1:0]    ready_s;
    logic [15:0]   ma_s, mb_s;
    logic          gsel_s;
    logic [15:0]   ga_s, gb_s;
    logic [31:0]   prod_s;

    logic [SD-1:0] pv_q;
    logic [2:0]    ptag_q [SD];   // {owner1, owner0, para_mode}
    logic [31:0]   pp_q   [SD];

    logic          feed_v_s;
    logic [2:0]    feed_tag_s;
    logic [31:0]   feed_p_s;

    logic [1:0]    rsp_valid_q;
    logic [31:0]   rsp_p0_q, rsp_p1_q;

    // Requester that would be served: rr on contention, else the lone valid one.
    assign gsel_s = (req_valid == 2'b11) ? rr_q : req_valid[1];
    assign ga_s   = gsel_s ? req_a1 : req_a0;
    assign gb_s   = gsel_s ? req_b1 : req_b0;

    // Issue decision, operand steering and pair-wait FSM next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        issue_s = 1'b0;
        para_s  = 1'b0;
        own_s   = 2'b00;
        ma_s    = 16'h0000;
        mb_s    = 16'h0000;
        if (req_valid == 2'b11 && req_mode == 2'b11) begin
            // Pair: requester 0 in the lo lane, requester 1 in the hi lane.
            state_d = IDLE;
            issue_s = 1'b1;
            para_s  = 1'b1;
            own_s   = 2'b11;
            ma_s    = {req_a1[7:0], req_a0[7:0]};
            mb_s    = {req_b1[7:0], req_b0[7:0]};
        end else if (req_valid == 2'b00) begin
            state_d = IDLE;
        end else begin
            // Contention (rr grant) or a lone request.
            // A lone 8-bit request may hold off to wait for a partner.
            if (req_valid == 2'b11 || !req_mode[gsel_s] ||
                (state_q == WAIT_PAIR && cnt_q == CW'(0)) ||
                (state_q == IDLE && PAIR_WAIT == 0)) begin
                state_d = IDLE;
                issue_s = 1'b1;
                own_s   = gsel_s ? 2'b10 : 2'b01;
                if (req_valid == 2'b11) begin
                    rr_d = ~rr_q;
                end else begin
                    rr_d = rr_q;
                end
                if (req_mode[gsel_s]) begin
                    // Single 8-bit op in its own lane; the other lane gets zeros.
                    para_s = 1'b1;
                    ma_s   = gsel_s ? {ga_s[7:0], 8'h00} : {8'h00, ga_s[7:0]};
                    mb_s   = gsel_s ? {gb_s[7:0], 8'h00} : {8'h00, gb_s[7:0]};
                end else begin
                    ma_s = ga_s;
                    mb_s = gb_s;
                end
            end else if (state_q == IDLE) begin
                state_d = WAIT_PAIR;
                cnt_d   = CW'(PAIR_WAIT - 1);
            end else begin
                cnt_d = cnt_q - CW'(1);
            end
        end
    end

    assign ready_s   = own_s;
    assign req_ready = rst ? 2'b00 : ready_s;

    // Variable-width multiplier: two independent 8x8 lanes, or one 16x16 product.
    always_comb begin
        prod_s = 32'h0000_0000;
        if (para_s) begin
            prod_s[15:0]  = {8'h00, ma_s[7:0]}  * {8'h00, mb_s[7:0]};
            prod_s[31:16] = {8'h00, ma_s[15:8]} * {8'h00, mb_s[15:8]};
        end else begin
            prod_s = {16'h0000, ma_s} * {16'h0000, mb_s};
        end
    end

    // FSM state, wait counter and round-robin pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= CW'(0);
            rr_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
        end
    end

    // Product pipeline with owner/mode tags; the valids are cleared on reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            pv_q <= '0;
            for (int k = 0; k < SD; k++) begin
                ptag_q[k] <= 3'b000;
                pp_q[k]   <= 32'h0000_0000;
            end
        end else begin
            pv_q[0]   <= issue_s;
            ptag_q[0] <= {own_s, para_s};
            pp_q[0]   <= prod_s;
            for (int k = 1; k < SD; k++) begin
                pv_q[k]   <= pv_q[k-1];
                ptag_q[k] <= ptag_q[k-1];
                pp_q[k]   <= pp_q[k-1];
            end
        end
    end

    // With LAT == 1 the output registers are fed directly by the issue stage.
    generate
        if (LAT == 1) begin : g_feed_direct
            assign feed_v_s   = issue_s;
            assign feed_tag_s = {own_s, para_s};
            assign feed_p_s   = prod_s;
        end else begin : g_feed_pipe
            assign feed_v_s   = pv_q[SD-1];
            assign feed_tag_s = ptag_q[SD-1];
            assign feed_p_s   = pp_q[SD-1];
        end
    endgenerate

    // Response registers: steer lane or full product to owners, hold otherwise.
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= 2'b00;
            rsp_p0_q    <= 32'h0000_0000;
            rsp_p1_q    <= 32'h0000_0000;
        end else begin
            rsp_valid_q <= feed_v_s ? feed_tag_s[2:1] : 2'b00;
            if (feed_v_s && feed_tag_s[1]) begin
                rsp_p0_q <= feed_tag_s[0] ? {16'h0000, feed_p_s[15:0]} : feed_p_s;
            end else begin
                rsp_p0_q <= rsp_p0_q;
            end
            if (feed_v_s && feed_tag_s[2]) begin
                rsp_p1_q <= feed_tag_s[0] ? {16'h0000, feed_p_s[31:16]} : feed_p_s;
            end else begin
                rsp_p1_q <= rsp_p1_q;
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_p0    = rsp_p0_q;
    assign rsp_p1    = rsp_p1_q;

`ifdef VBM_SCHED_STATS_EN
    logic [CNT_W-1:0] n16_q, npair_q, nsgl8_q;

    // Wrapping issue counters, split by issue kind.
    always_ff @(posedge clk) begin
        if (rst) begin
            n16_q   <= '0;
            npair_q <= '0;
            nsgl8_q <= '0;
        end else if (issue_s) begin
            if (!para_s) begin
                n16_q <= n16_q + CNT_W'(1);
            end else if (own_s == 2'b11) begin
                npair_q <= npair_q + CNT_W'(1);
            end else begin
                nsgl8_q <= nsgl8_q + CNT_W'(1);
            end
        end else begin
            n16_q   <= n16_q;
            npair_q <= npair_q;
            nsgl8_q <= nsgl8_q;
        end
    end

    assign stat_n16   = n16_q;
    assign stat_npair = npair_q;
    assign stat_nsgl8 = nsgl8_q;
`else
    assign stat_n16   = '0;
    assign stat_npair = '0;
    assign stat_nsgl8 = '0;
`endif

endmodule

// File: tb/tb_vbm_sched.sv
// Directed self-checking bench for vbm_sched (LAT=2, PAIR_WAIT=3, CNT_W=16).
// Inputs are driven 1 ns after the rising edge, and outputs are checked 1 ns later.
module tb_vbm_sched;

`ifdef VBM_SCHED_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_ready, req_mode, rsp_valid;
    logic [15:0] req_a0, req_b0, req_a1, req_b1;
    logic [31:0] rsp_p0, rsp_p1;
    logic [15:0] stat_n16, stat_npair, stat_nsgl8;

    int n_tests = 0;
    int n_fail  = 0;

    vbm_sched #(.LAT(2), .PAIR_WAIT(3), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_mode   (req_mode),
        .req_a0     (req_a0),
        .req_b0     (req_b0),
        .req_a1     (req_a1),
        .req_b1     (req_b1),
        .rsp_valid  (rsp_valid),
        .rsp_p0     (rsp_p0),
        .rsp_p1     (rsp_p1),
        .stat_n16   (stat_n16),
        .stat_npair (stat_npair),
        .stat_nsgl8 (stat_nsgl8)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [1:0] v, input logic [1:0] m,
                         input logic [15:0] a0, input logic [15:0] b0,
                         input logic [15:0] a1, input logic [15:0] b1);
        req_valid = v;
        req_mode  = m;
        req_a0    = a0;
        req_b0    = b0;
        req_a1    = a1;
        req_b1    = b1;
        #1;
    endtask

    task automatic check_stats(input string tag, input int e16, input int epair, input int esgl);
        check_eq({tag, "_n16"},   {16'h0, stat_n16},   STATS ? 32'(e16)   : 32'h0);
        check_eq({tag, "_npair"}, {16'h0, stat_npair}, STATS ? 32'(epair) : 32'h0);
        check_eq({tag, "_nsgl8"}, {16'h0, stat_nsgl8}, STATS ? 32'(esgl)  : 32'h0);
    endtask

    initial begin
        rst = 1'b1;
        drive(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        step();
        step();
        check_eq("rst_ready", {30'h0, req_ready}, 32'h0);
        check_eq("rst_rspv",  {30'h0, rsp_valid}, 32'h0);
        check_eq("rst_p0",    rsp_p0, 32'h0);
        check_eq("rst_p1",    rsp_p1, 32'h0);
        check_stats("rst", 0, 0, 0);
        rst = 1'b0;

        // Lone 16-bit request.
        step();
        drive(2'b01, 2'b00, 16'h1234, 16'h5678, 16'h0, 16'h0);
        check_eq("l16_ready", {30'h0, req_ready}, 32'h1);
        step();
        drive(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        check_eq("l16_early", {30'h0, rsp_valid}, 32'h0);
        step();
        check_eq("l16_rspv", {30'h0, rsp_valid}, 32'h1);
        check_eq("l16_p0",   rsp_p0, 32'h0626_0060);
        step();
        check_eq("l16_pulse", {30'h0, rsp_valid}, 32'h0);
        check_eq("l16_hold",  rsp_p0, 32'h0626_0060);

        // Coincident 8-bit requests are paired.
        step();
        drive(2'b11, 2'b11, 16'h0012, 16'h0034, 16'h00FF, 16'h00FF);
        check_eq("pair_ready", {30'h0, req_ready}, 32'h3);
        step();
        drive(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        step();
        check_eq("pair_rspv", {30'h0, rsp_valid}, 32'h3);
        check_eq("pair_p0",   rsp_p0, 32'h0000_03A8);
        check_eq("pair_p1",   rsp_p1, 32'h0000_FE01);

        // A lone 8-bit request times out after PAIR_WAIT cycles.
        step();
        drive(2'b10, 2'b10, 16'h0, 16'h0, 16'h000F, 16'h0010);
        for (int i = 0; i < 3; i++) begin
            check_eq("wait_noready", {30'h0, req_ready}, 32'h0);
            step();
        end
        check_eq("wait_ready", {30'h0, req_ready}, 32'h2);
        step();
        drive(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        step();
        check_eq("wait_rspv",  {30'h0, rsp_valid}, 32'h2);
        check_eq("wait_p1",    rsp_p1, 32'h0000_00F0);
        check_eq("wait_p0hold", rsp_p0, 32'h0000_03A8);

        // A partner arrives one cycle late and forms a pair.
        step();
        drive(2'b01, 2'b01, 16'h0003, 16'h0005, 16'h0, 16'h0);
        check_eq("late_hold", {30'h0, req_ready}, 32'h0);
        step();
        drive(2'b11, 2'b11, 16'h0003, 16'h0005, 16'h0007, 16'h0009);
        check_eq("late_ready", {30'h0, req_ready}, 32'h3);
        step();
        drive(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        step();
        check_eq("late_rspv", {30'h0, rsp_valid}, 32'h3);
        check_eq("late_p0",   rsp_p0, 32'h0000_000F);
        check_eq("late_p1",   rsp_p1, 32'h0000_003F);
        check_stats("late", 1, 2, 1);

        // 16-bit contention alternates grants, starting with requester 0.
        step();
        drive(2'b11, 2'b00, 16'hFFFF, 16'hFFFF, 16'hFFFF, 16'hFFFF);
        check_eq("rr_g0", {30'h0, req_ready}, 32'h1);
        step();
        check_eq("rr_g1", {30'h0, req_ready}, 32'h2);
        step();
        check_eq("rr_g2",  {30'h0, req_ready}, 32'h1);
        check_eq("rr_r0v", {30'h0, rsp_valid}, 32'h1);
        check_eq("rr_r0p", rsp_p0, 32'hFFFE_0001);
        step();
        check_eq("rr_g3",  {30'h0, req_ready}, 32'h2);
        check_eq("rr_r1v", {30'h0, rsp_valid}, 32'h2);
        check_eq("rr_r1p", rsp_p1, 32'hFFFE_0001);

        // Contention with an 8-bit grant: a single op in the lo lane.
        step();
        drive(2'b11, 2'b01, 16'hAB12, 16'hCD03, 16'h0002, 16'h8000);
        check_eq("mix_g0",  {30'h0, req_ready}, 32'h1);
        check_eq("mix_r2v", {30'h0, rsp_valid}, 32'h1);
        step();
        drive(2'b10, 2'b01, 16'h0, 16'h0, 16'h0002, 16'h8000);
        check_eq("mix_g1",  {30'h0, req_ready}, 32'h2);
        check_eq("mix_r3v", {30'h0, rsp_valid}, 32'h2);
        step();
        drive(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        check_eq("mix_sglv", {30'h0, rsp_valid}, 32'h1);
        check_eq("mix_sglp", rsp_p0, 32'h0000_0036);
        step();
        check_eq("mix_16v", {30'h0, rsp_valid}, 32'h2);
        check_eq("mix_16p", rsp_p1, 32'h0001_0000);
        check_stats("mix", 6, 2, 2);

        // Reset one cycle after an issue discards the op.
        step();
        drive(2'b01, 2'b00, 16'h0002, 16'h0003, 16'h0, 16'h0);
        check_eq("mrst_ready", {30'h0, req_ready}, 32'h1);
        step();
        drive(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        rst = 1'b1;
        step();
        check_eq("mrst_rspv", {30'h0, rsp_valid}, 32'h0);
        check_eq("mrst_p0",   rsp_p0, 32'h0);
        check_eq("mrst_p1",   rsp_p1, 32'h0);
        check_stats("mrst", 0, 0, 0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_eq("mrst_quiet", {30'h0, rsp_valid}, 32'h0);
        end
        drive(2'b01, 2'b00, 16'h0007, 16'h0006, 16'h0, 16'h0);
        check_eq("post_ready", {30'h0, req_ready}, 32'h1);
        step();
        drive(2'b00, 2'b00, 16'h0, 16'h0, 16'h0, 16'h0);
        step();
        check_eq("post_rspv", {30'h0, rsp_valid}, 32'h1);
        check_eq("post_p0",   rsp_p0, 32'h0000_002A);
        check_stats("post", 1, 0, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
